// File: rtl/subservient_prog_loader.sv
// -----------------------------------------------------------------------------
// subservient_prog_loader
//
// Purpose:
//   Program loader that sits in front of the SRAM arbiter's Wishbone port.
//   It takes a little-endian byte stream and packs every 4 bytes into a word.
//   Each completed word goes out as one Wishbone write, starting at word 0 and
//   counting upward. The CPU stays in reset until `words` words are written.
//
// Parameters:
//   depth  total SRAM depth in bytes (same value as the arbiter)
//   words  number of words to load, 1..(depth/2)/4
//   aw     $clog2(depth), derived; do not override
//
// Ports:
//   i_clk      clock
//   i_rst      synchronous reset, active high
//   i_data     stream byte
//   i_valid    i_data valid
//   o_ready    loader accepts a byte; a transfer happens on i_valid & o_ready
//   o_wb_adr   word address (arbiter i_wb_adr[aw-1:2])
//   o_wb_dat   write data
//   o_wb_sel   byte select, 4'hf while o_wb_stb
//   o_wb_we    write enable, 1 while o_wb_stb
//   o_wb_stb   request, held until i_wb_ack
//   i_wb_ack   single-cycle acknowledge
//   o_done     all words written, sticky until reset
//   o_cpu_rst  CPU reset hold, registered ~o_done
// -----------------------------------------------------------------------------
module subservient_prog_loader #(
    parameter int depth = 256,
    parameter int words = (depth / 2) / 4,
    parameter int aw    = $clog2(depth)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [7:0]    i_data,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [aw-3:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_stb,
    input  logic          i_wb_ack,
    output logic          o_done,
    output logic          o_cpu_rst
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Address of the final word; the address counter stops here instead of
    // wrapping.
    localparam logic [aw-3:0] LAST_ADR = (aw-2)'(words - 1);

    state_t          r_state;
    logic [1:0]      r_byte_cnt;
    logic [aw-3:0]   r_adr;
    logic [31:0]     r_dat;
    logic [3:0]      r_sel;
    logic            r_we;
    logic            r_stb;
    logic            r_done;
    logic            r_cpu_rst;

    logic            w_accept;
    logic [3:0]      w_lane_hit;

    // Combinational ready. It is masked by reset so that no byte is taken
    // during the reset cycle.
    assign o_ready  = (r_state == FILL) && !i_rst;
    assign w_accept = o_ready && i_valid;

    // One-hot byte lane selected by the current byte count.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane_hit[gi] = (r_byte_cnt == 2'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= FILL;
            r_byte_cnt <= 2'd0;
            r_adr      <= '0;
            r_dat      <= 32'd0;
            r_sel      <= 4'd0;
            r_we       <= 1'b0;
            r_stb      <= 1'b0;
            r_done     <= 1'b0;
            r_cpu_rst  <= 1'b1;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        for (int b = 0; b < 4; b++) begin
                            if (w_lane_hit[b]) begin
                                r_dat[8*b +: 8] <= i_data;
                            end
                        end
                        if (r_byte_cnt == 2'd3) begin
                            // Word complete: raise the request on the next edge.
                            r_byte_cnt <= 2'd0;
                            r_state    <= WRITE;
                            r_stb      <= 1'b1;
                            r_we       <= 1'b1;
                            r_sel      <= 4'hf;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end

                WRITE: begin
                    // Address, data and strobes stay frozen until the arbiter
                    // acknowledges. The ack latency has no upper bound.
                    if (i_wb_ack) begin
                        r_stb <= 1'b0;
                        r_we  <= 1'b0;
                        r_sel <= 4'd0;
                        if (r_adr == LAST_ADR) begin
                            r_state   <= DONE;
                            r_done    <= 1'b1;
                            r_cpu_rst <= 1'b0;
                        end else begin
                            r_adr   <= r_adr + 1'b1;
                            r_state <= FILL;
                        end
                    end
                end

                DONE: begin
                    // Terminal: the stream is ignored and no bus traffic occurs.
                end

                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    assign o_wb_adr  = r_adr;
    assign o_wb_dat  = r_dat;
    assign o_wb_sel  = r_sel;
    assign o_wb_we   = r_we;
    assign o_wb_stb  = r_stb;
    assign o_done    = r_done;
    assign o_cpu_rst = r_cpu_rst;

endmodule

// File: tb/tb_subservient_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_subservient_prog_loader
//
// Self-checking bench for the byte-stream program loader. It contains:
//   - a table of single-word vectors with hand-computed packed words and
//     Wishbone acknowledge delays,
//   - hand-written sequences for reset, spurious acknowledges, reset during a
//     partial word, and stream activity after completion,
//   - a random full load with gaps on i_valid. A Wishbone slave with random
//     latency stores each write in a memory array, and every word is compared
//     against the expected program.
// -----------------------------------------------------------------------------
module tb_subservient_prog_loader;

    localparam int DEPTH = 256;
    localparam int WORDS = (DEPTH / 2) / 4;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [7:0]    i_data = 8'd0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [AW-3:0] o_wb_adr;
    logic [31:0]   o_wb_dat;
    logic [3:0]    o_wb_sel;
    logic          o_wb_we;
    logic          o_wb_stb;
    logic          i_wb_ack;
    logic          o_done;
    logic          o_cpu_rst;

    logic          man_ack = 1'b0;
    logic          slv_ack = 1'b0;
    logic          auto_ack = 1'b0;
    assign i_wb_ack = man_ack | slv_ack;

    int errors = 0;
    int checks = 0;

    // Memory written through the bus, plus a log of every write.
    logic [31:0]   mem [WORDS];
    int            wr_count = 0;
    logic [31:0]   wr_dat_q [$];
    int            wr_adr_q [$];

    subservient_prog_loader #(.depth(DEPTH)) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_wb_adr  (o_wb_adr),
        .o_wb_dat  (o_wb_dat),
        .o_wb_sel  (o_wb_sel),
        .o_wb_we   (o_wb_we),
        .o_wb_stb  (o_wb_stb),
        .i_wb_ack  (i_wb_ack),
        .o_done    (o_done),
        .o_cpu_rst (o_cpu_rst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        man_ack = 1'b0;
        i_rst   = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        #1;
        wr_count = 0;
        wr_dat_q.delete();
        wr_adr_q.delete();
    endtask

    // Offer a byte and hold it until it is accepted. Ready is stable between
    // edges, so its value now is the value the DUT sees at the next edge.
    task automatic stream_byte(input logic [7:0] b);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        i_data  = b;
        i_valid = 1'b1;
        while (!acc && n < 200) begin
            acc = o_ready;
            tick();
            n++;
        end
        i_valid = 1'b0;
        if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_writes(input int target);
        int n;
        n = 0;
        while (wr_count < target && n < 500) begin
            tick();
            n++;
        end
        chk("write_wait", wr_count, target);
    endtask

    // Bus monitor: one line per completed write, plus checks on the strobes.
    always @(posedge clk) begin
        if (!i_rst && o_wb_stb && i_wb_ack) begin
            $display("wb write #%0d adr=%0d dat=%h sel=%h we=%0b",
                     wr_count, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we);
            chk("wr_sel", {28'd0, o_wb_sel}, 32'hf);
            chk("wr_we", {31'd0, o_wb_we}, 32'd1);
            mem[o_wb_adr] = o_wb_dat;
            wr_dat_q.push_back(o_wb_dat);
            wr_adr_q.push_back(int'(o_wb_adr));
            wr_count++;
        end
    end

    // Wishbone slave with random latency, active only when auto_ack is set.
    initial begin
        forever begin
            tick();
            if (auto_ack && o_wb_stb && !slv_ack && !i_rst) begin
                repeat ($urandom_range(0, 4)) tick();
                slv_ack = 1'b1;
                tick();
                slv_ack = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]    b0, b1, b2, b3;
        int            delay;
        logic [31:0]   exp_dat;
        logic [AW-3:0] exp_adr;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [7:0]  bs [4];
        logic [31:0] prog [WORDS];
        logic [31:0] w5 [4];
        logic [31:0] saved_dat;
        int n;

        vecs[0] = '{8'h78, 8'h56, 8'h34, 8'h12, 6, 32'h12345678, 6'd0};
        vecs[1] = '{8'hef, 8'hbe, 8'had, 8'hde, 0, 32'hdeadbeef, 6'd1};
        vecs[2] = '{8'h01, 8'h02, 8'h03, 8'h04, 2, 32'h04030201, 6'd2};
        vecs[3] = '{8'hff, 8'h00, 8'hff, 8'h00, 1, 32'h00ff00ff, 6'd3};

        // ---- 1: reset values -------------------------------------------
        i_rst = 1'b1;
        tick();
        tick();
        chk("rst_stb", {31'd0, o_wb_stb}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
        chk("rst_ready_in_reset", {31'd0, o_ready}, 32'd0);
        chk("rst_adr", {26'd0, o_wb_adr}, 32'd0);
        chk("rst_dat", o_wb_dat, 32'd0);
        i_rst = 1'b0;
        #1;
        chk("ready_after_release", {31'd0, o_ready}, 32'd1);

        // ---- 2: table of single words with a manual ack ----------------
        for (int r = 0; r < 4; r++) begin
            bs[0] = vecs[r].b0; bs[1] = vecs[r].b1;
            bs[2] = vecs[r].b2; bs[3] = vecs[r].b3;
            for (int k = 0; k < 4; k++) begin
                i_data  = bs[k];
                i_valid = 1'b1;
                chk("tbl_ready_fill", {31'd0, o_ready}, 32'd1);
                tick();
            end
            i_valid = 1'b0;
            chk("tbl_stb", {31'd0, o_wb_stb}, 32'd1);
            chk("tbl_adr", {26'd0, o_wb_adr}, {26'd0, vecs[r].exp_adr});
            chk("tbl_dat", o_wb_dat, vecs[r].exp_dat);
            chk("tbl_sel", {28'd0, o_wb_sel}, 32'hf);
            chk("tbl_we", {31'd0, o_wb_we}, 32'd1);
            chk("tbl_ready_write", {31'd0, o_ready}, 32'd0);
            for (int d = 0; d < vecs[r].delay; d++) begin
                // Offer a byte while waiting; it must not be taken.
                i_valid = 1'b1;
                i_data  = 8'haa;
                tick();
                chk("tbl_hold_stb", {31'd0, o_wb_stb}, 32'd1);
                chk("tbl_hold_dat", o_wb_dat, vecs[r].exp_dat);
                chk("tbl_hold_adr", {26'd0, o_wb_adr}, {26'd0, vecs[r].exp_adr});
            end
            i_valid = 1'b0;
            man_ack = 1'b1;
            tick();
            man_ack = 1'b0;
            chk("tbl_stb_after_ack", {31'd0, o_wb_stb}, 32'd0);
            chk("tbl_ready_after_ack", {31'd0, o_ready}, 32'd1);
            chk("tbl_adr_after_ack", {26'd0, o_wb_adr}, {26'd0, vecs[r].exp_adr} + 32'd1);
        end
        chk("tbl_write_count", wr_count, 4);

        // ---- 4a: spurious ack in FILL mid-word -------------------------
        stream_byte(8'h11);
        stream_byte(8'h22);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("spur_fill_adr", {26'd0, o_wb_adr}, 32'd4);
        chk("spur_fill_stb", {31'd0, o_wb_stb}, 32'd0);
        stream_byte(8'h33);
        stream_byte(8'h44);
        chk("spur_fill_dat", o_wb_dat, 32'h44332211);
        chk("spur_fill_stb_now", {31'd0, o_wb_stb}, 32'd1);

        // ---- 3: full random load ---------------------------------------
        do_reset();
        auto_ack = 1'b1;
        for (int w = 0; w < WORDS; w++) prog[w] = 32'ha5000000 | w;
        for (int w = 0; w < WORDS; w++) begin
            for (int k = 0; k < 4; k++) begin
                repeat ($urandom_range(0, 2)) tick();
                if (k == 0 && w < WORDS - 1)
                    chk("load_cpu_rst_held", {31'd0, o_cpu_rst}, 32'd1);
                stream_byte(8'((prog[w] >> (8 * k)) & 32'hff));
            end
        end
        n = 0;
        while (!o_done && n < 500) begin
            tick();
            n++;
        end
        chk("load_done", {31'd0, o_done}, 32'd1);
        chk("load_cpu_rst", {31'd0, o_cpu_rst}, 32'd0);
        chk("load_writes", wr_count, WORDS);
        for (int w = 0; w < WORDS; w++) chk("load_readback", mem[w], prog[w]);
        for (int w = 0; w < WORDS && w < wr_adr_q.size(); w++)
            chk("load_order", wr_adr_q[w], w);
        auto_ack = 1'b0;

        // ---- 6: stream activity after done -----------------------------
        for (int k = 0; k < 8; k++) begin
            i_data  = 8'($urandom);
            i_valid = 1'b1;
            chk("post_ready", {31'd0, o_ready}, 32'd0);
            tick();
            chk("post_stb", {31'd0, o_wb_stb}, 32'd0);
            chk("post_done", {31'd0, o_done}, 32'd1);
        end
        i_valid = 1'b0;
        repeat (10) tick();
        chk("post_no_extra_write", wr_count, WORDS);

        // ---- 4b: spurious ack in DONE ----------------------------------
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        tick();
        chk("spur_done_done", {31'd0, o_done}, 32'd1);
        chk("spur_done_adr", {26'd0, o_wb_adr}, WORDS - 1);
        chk("spur_done_stb", {31'd0, o_wb_stb}, 32'd0);
        chk("spur_done_cpu_rst", {31'd0, o_cpu_rst}, 32'd0);

        // ---- 5: reset in the middle of word 3 --------------------------
        do_reset();
        auto_ack = 1'b1;
        for (int w = 0; w < 4; w++) w5[w] = $urandom;
        for (int w = 0; w < 3; w++)
            for (int k = 0; k < 4; k++) stream_byte(8'((w5[w] >> (8 * k)) & 32'hff));
        wait_writes(3);
        stream_byte(8'hc3);
        stream_byte(8'h5a);
        do_reset();
        chk("mid_rst_adr", {26'd0, o_wb_adr}, 32'd0);
        chk("mid_rst_stb", {31'd0, o_wb_stb}, 32'd0);
        for (int k = 0; k < 4; k++) stream_byte(8'((w5[3] >> (8 * k)) & 32'hff));
        wait_writes(1);
        if (wr_count >= 1) begin
            chk("mid_rst_new_adr", wr_adr_q[0], 0);
            chk("mid_rst_new_dat", wr_dat_q[0], w5[3]);
        end
        saved_dat = o_wb_dat;
        chk("mid_rst_hold_dat", saved_dat, w5[3]);
        auto_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
